serial_cmp_iter: RTL and testbench

- Parametrised, sequential successor to the three-cell iterative comparator.
- Evaluates one comparison of two WIDTH-bit operands A and B.
- Scans bits MSB to LSB, one bit per clock, using a single reused "typical cell" datapath.
- Mode inputs z,y select the relation reported on f. A start/busy/done handshake lets a controller launch comparisons back to back.

---
 rtl/serial_cmp_pkg.sv | 35 +++
 rtl/cmp_cell_step.sv | 32 +++
 rtl/serial_cmp_iter.sv | 164 ++++++++++++++++
 tb/tb_serial_cmp_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared types and constants for the serial iterative
// comparator (serial_cmp_iter).
//   state_t      - controller states IDLE / RUN / DONE
//   MODE_*       - {z,y} relation selectors
//   mode_result  - maps the final (g_eq, g_gt) flags onto the selected relation
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_EQ = 2'b00;  // A == B
  localparam logic [1:0] MODE_GT = 2'b01;  // A >  B
  localparam logic [1:0] MODE_LT = 2'b10;  // A <  B
  localparam logic [1:0] MODE_NE = 2'b11;  // A != B

  // Final flags: g_eq=1 means equal; otherwise g_gt tells A>B (1) or A<B (0).
  function automatic logic mode_result(input logic [1:0] mode,
                                       input logic       g_eq,
                                       input logic       g_gt);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_EQ: r = g_eq;
      MODE_GT: r = !g_eq && g_gt;
      MODE_LT: r = !g_eq && !g_gt;
      MODE_NE: r = !g_eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_cell_step.sv
// cmp_cell_step: one step of the MSB-first magnitude comparison ("typical
// cell"). Combinational only; reused every clock by serial_cmp_iter.
// Ports:
//   a_bit, b_bit  - operand bits at the current scan position
//   g_eq_in       - higher-order bits seen so far are all equal
//   g_gt_in       - decision so far (meaningful once g_eq_in=0)
//   invert        - swap the decision sense (two's complement sign bit)
//   g_eq_out      - updated equal flag
//   g_gt_out      - updated greater-than flag
module cmp_cell_step (
  input  logic a_bit,
  input  logic b_bit,
  input  logic g_eq_in,
  input  logic g_gt_in,
  input  logic invert,
  output logic g_eq_out,
  output logic g_gt_out
);

  // The first differing bit decides; after that the flags pass straight
  // through so the decision freezes for the remainder of the scan.
  always_comb begin
    g_eq_out = g_eq_in;
    g_gt_out = g_gt_in;
    if (g_eq_in && (a_bit != b_bit)) begin
      g_eq_out = 1'b0;
      // On a sign bit a set bit means "more negative", so B's bit decides.
      g_gt_out = invert ? b_bit : a_bit;
    end
  end

endmodule

// File: rtl/serial_cmp_iter.sv
// serial_cmp_iter: bit-serial WIDTH-bit comparator. Scans the captured
// operands MSB to LSB, one bit per clock, through a single cmp_cell_step,
// then reports the relation selected by {z,y} on f.
// Parameters:
//   WIDTH  - operand width, 2..32
//   SIGNED - 1: two's complement operands, 0: unsigned
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - launch request, honoured only in IDLE
//   A, B   - operands, captured on an accepted start
//   z, y   - mode select {z,y}, captured with the operands
//   busy   - comparison in progress (RUN)
//   done   - one-cycle pulse; f/gt/eq valid from this cycle
//   f      - selected relation, held until the next done or reset
//   gt, eq - final A>B / A==B flags, held with f
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN - leave RUN in the cycle after the first
//   differing bit is found instead of always scanning all WIDTH bits.
//   Results are identical; only latency changes.
module serial_cmp_iter
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             z,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             f,
  output logic             gt,
  output logic             eq
);

  localparam int unsigned    IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_cmp_iter: WIDTH must be in 2..32");
  end

  state_t             state;
  state_t             state_nx;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         mode_q;
  logic [IDX_W-1:0]   idx;
  logic               g_eq;
  logic               g_gt;

  logic               cell_eq;
  logic               cell_gt;
  logic               cell_invert;

  logic               f_q;
  logic               gt_q;
  logic               eq_q;

  assign cell_invert = SIGNED && (idx == IDX_MSB);

  cmp_cell_step u_cell (
    .a_bit    (a_q[idx]),
    .b_bit    (b_q[idx]),
    .g_eq_in  (g_eq),
    .g_gt_in  (g_gt),
    .invert   (cell_invert),
    .g_eq_out (cell_eq),
    .g_gt_out (cell_gt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        // A decision already made in an earlier step ends the scan; the
        // cell passes frozen flags through, so the result is unchanged.
        if (!g_eq || (idx == '0)) state_nx = DONE;
`else
        if (idx == '0) state_nx = DONE;
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign f  = f_q;
  assign gt = gt_q;
  assign eq = eq_q;

  // Datapath: operand capture, scan registers and held results.
  // Results are loaded on the RUN->DONE edge so they are already valid
  // during the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      idx    <= '0;
      g_eq   <= 1'b1;
      g_gt   <= 1'b0;
      f_q    <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            mode_q <= {z, y};
            idx    <= IDX_MSB;
            g_eq   <= 1'b1;
            g_gt   <= 1'b0;
          end
        end
        RUN: begin
          g_eq <= cell_eq;
          g_gt <= cell_gt;
          if (idx != '0) idx <= idx - IDX_W'(1);
          if (state_nx == DONE) begin
            f_q  <= mode_result(mode_q, cell_eq, cell_gt);
            gt_q <= cell_gt;
            eq_q <= cell_eq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_iter.sv
module tb_serial_cmp_iter;
  import serial_cmp_pkg::*;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in  = '0;
  logic [W-1:0] b_in  = '0;
  logic         z_in  = 1'b0;
  logic         y_in  = 1'b0;

  logic busy_u, done_u, f_u, gt_u, eq_u;
  logic busy_s, done_s, f_s, gt_s, eq_s;

  always #5 clk = ~clk;

  serial_cmp_iter #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
    .z(z_in), .y(y_in), .busy(busy_u), .done(done_u), .f(f_u),
    .gt(gt_u), .eq(eq_u));

  serial_cmp_iter #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
    .z(z_in), .y(y_in), .busy(busy_s), .done(done_s), .f(f_s),
    .gt(gt_s), .eq(eq_s));

  typedef struct {
    string name;
    logic  f;
    logic  gt;
    logic  eq;
    int    lat;
    int    accept;
  } exp_t;

  // Hand-computed vectors: expected results for unsigned (u) and signed (s)
  // instances, and k = bits scanned up to the first differing bit (W if equal).
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic       fu;
    logic       gtu;
    logic       eqx;
    logic       fs;
    logic       gts;
    int         k;
  } vec_t;

  vec_t vecs[11] = '{
    '{8'h5A, 8'h3C, MODE_GT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2},
    '{8'h5A, 8'h3C, MODE_LT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2},
    '{8'hA5, 8'hA5, MODE_EQ, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8},
    '{8'hA5, 8'hA5, MODE_NE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8},
    '{8'hFF, 8'h01, MODE_LT, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1},
    '{8'h80, 8'h00, MODE_GT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1},
    '{8'h00, 8'h01, MODE_NE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8},
    '{8'h7F, 8'h80, MODE_GT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1},
    '{8'h12, 8'h13, MODE_LT, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8},
    '{8'hC0, 8'hC4, MODE_GT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6},
    '{8'hFE, 8'hFD, MODE_EQ, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7}
  };

  exp_t q_u[$];
  exp_t q_s[$];
  exp_t e_u;
  exp_t e_s;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges  = 0;

  always @(posedge clk) edges++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Cycle in which done appears, counting the start cycle as cycle 0.
  function automatic int exp_lat(input int k);
    int l;
    l = W + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (k < W) l = k + 2;
`endif
    return l;
  endfunction

  // Monitors: pop and compare whenever an instance presents done.
  always @(negedge clk) begin
    if (rst_n && done_u) begin
      if (q_u.size() == 0) begin
        fail_now("unexpected_done_u");
      end else begin
        e_u = q_u.pop_front();
        check({e_u.name, "_f_u"},    f_u,  e_u.f);
        check({e_u.name, "_gt_u"},   gt_u, e_u.gt);
        check({e_u.name, "_eq_u"},   eq_u, e_u.eq);
        check({e_u.name, "_lat_u"},  edges - e_u.accept + 1, e_u.lat);
        check({e_u.name, "_busy_u"}, busy_u, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_s) begin
      if (q_s.size() == 0) begin
        fail_now("unexpected_done_s");
      end else begin
        e_s = q_s.pop_front();
        check({e_s.name, "_f_s"},   f_s,  e_s.f);
        check({e_s.name, "_gt_s"},  gt_s, e_s.gt);
        check({e_s.name, "_eq_s"},  eq_s, e_s.eq);
        check({e_s.name, "_lat_s"}, edges - e_s.accept + 1, e_s.lat);
      end
    end
  end

  // Called at a negedge; waits for both instances to be in IDLE, then
  // presents start for one cycle.
  task automatic issue(input int i, input bit expect_done);
    int t;
    exp_t e;
    t = 0;
    while ((busy_u || done_u || busy_s || done_s) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now($sformatf("idle_wait_v%0d", i));
    a_in  = vecs[i].a;
    b_in  = vecs[i].b;
    {z_in, y_in} = vecs[i].mode;
    start = 1'b1;
    if (expect_done) begin
      e.name   = $sformatf("v%0d", i);
      e.accept = edges + 1;
      e.lat    = exp_lat(vecs[i].k);
      e.f  = vecs[i].fu;  e.gt = vecs[i].gtu; e.eq = vecs[i].eqx;
      q_u.push_back(e);
      e.f  = vecs[i].fs;  e.gt = vecs[i].gts;
      q_s.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_busy_run", i), {busy_u, busy_s}, 2'b11);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now({nm, "_drain"});
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_busy"}, {busy_u, busy_s}, 2'b00);
    check({nm, "_done"}, {done_u, done_s}, 2'b00);
    check({nm, "_f"},    {f_u, f_s},       2'b00);
    check({nm, "_gt"},   {gt_u, gt_s},     2'b00);
    check({nm, "_eq"},   {eq_u, eq_s},     2'b11);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All vectors issued back to back at the minimum interval.
    for (int i = 0; i < 11; i++) issue(i, 1'b1);
    drain("vectors");

    // start pulsed mid-RUN with other operands must be ignored.
    issue(2, 1'b1);
    @(negedge clk);
    a_in = 8'h00; b_in = 8'hFF; {z_in, y_in} = MODE_NE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = 8'h33;
    drain("ignore_start");

    // Reset in the 4th RUN cycle after a completed compare left f/gt/eq set.
    issue(5, 1'b1);
    drain("pre_abort");
    issue(3, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(7, 1'b1);
    drain("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
